// File: rtl/fifo_rr_pkg.sv
// Shared definitions for the round-robin FIFO controller: read FSM encoding,
// source-tag width helper and the field layout of a tagged FIFO word.
package fifo_rr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        VALID = 2'd2
    } rd_state_e;

    // Tag width for a given producer count; never below one bit.
    function automatic int req_w(input int n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

    // A FIFO word is {src, payload}: payload at the bottom, tag directly above it.
    localparam int PAYLOAD_LSB = 0;

    function automatic int tag_lsb(input int width);
        return width;
    endfunction

endpackage

// File: rtl/fifo_rr_controller_arbiter.sv
// Round-robin grant over N_REQ requesters; the search starts at rr_ptr,
// which moves past the winner whenever the caller reports an accepted grant.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int REQ_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             advance,
    output logic [REQ_W-1:0] grant,
    output logic             any
);

    logic [REQ_W-1:0] rr_ptr;
    logic [REQ_W:0]   idx;

    // Scan rr_ptr, rr_ptr+1, ... with an explicit wrap so odd N_REQ works.
    always_comb begin
        grant = '0;
        any   = 1'b0;
        idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = {1'b0, rr_ptr} + (REQ_W+1)'(i);
            if (idx >= (REQ_W+1)'(N_REQ))
                idx = idx - (REQ_W+1)'(N_REQ);
            if (!any && req[idx[REQ_W-1:0]]) begin
                any   = 1'b1;
                grant = idx[REQ_W-1:0];
            end
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk) begin
        if (rst)
            rr_ptr <= '0;
        else if (advance)
            rr_ptr <= (grant == REQ_W'(N_REQ - 1)) ? '0 : grant + REQ_W'(1);
    end

endmodule

// File: rtl/fifo_rr_controller.sv
// Round-robin write side and 1-cycle-latency read sequencer around an
// external FIFO holding {src, payload} words.
module fifo_rr_controller
    import fifo_rr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_REQ = 4,
    parameter int REQ_W = req_w(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   fifo_wr_en,
    output logic [WIDTH+REQ_W-1:0] fifo_din,
    input  logic                   fifo_full,
    output logic                   fifo_rd_en,
    input  logic [WIDTH+REQ_W-1:0] fifo_dout,
    input  logic                   fifo_empty,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic [REQ_W-1:0]       out_src,
    input  logic                   out_ready
);

    localparam int TAG_LSB = tag_lsb(WIDTH);

    logic [REQ_W-1:0] grant;
    logic             any;
    logic             accept;
    rd_state_e        state;

    rr_arbiter #(
        .N_REQ(N_REQ),
        .REQ_W(REQ_W)
    ) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req_valid),
        .advance(accept),
        .grant  (grant),
        .any    (any)
    );

    assign accept     = any && !fifo_full && !rst;
    assign req_ready  = accept ? (N_REQ'(1) << grant) : '0;
    assign fifo_wr_en = accept;
    assign fifo_din   = {grant, req_data[grant*WIDTH +: WIDTH]};

    // NOTE: the read strobe is decoded from the current state rather than
    // registered, otherwise first-word latency would grow by a cycle.
    assign fifo_rd_en = !rst && !fifo_empty &&
                        ((state == IDLE) || (state == VALID && out_ready));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    out_valid <= 1'b0;
                    if (!fifo_empty)
                        state <= PEND;
                end
                PEND: begin
                    out_src   <= fifo_dout[TAG_LSB +: REQ_W];
                    out_data  <= fifo_dout[PAYLOAD_LSB +: WIDTH];
                    out_valid <= 1'b1;
                    state     <= VALID;
                end
                VALID: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= fifo_empty ? IDLE : PEND;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rr_controller.sv
// Directed bench: a vector table for reset/arbitration/stall, then hand-written
// read sequences with the FIFO read port driven by the bench.
module tb_fifo_rr_controller;

    localparam int WIDTH = 8;
    localparam int N_REQ = 4;
    localparam int REQ_W = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       req_ready;
    logic                   fifo_wr_en;
    logic [WIDTH+REQ_W-1:0] fifo_din;
    logic                   fifo_full;
    logic                   fifo_rd_en;
    logic [WIDTH+REQ_W-1:0] fifo_dout;
    logic                   fifo_empty;
    logic                   out_valid;
    logic [WIDTH-1:0]       out_data;
    logic [REQ_W-1:0]       out_src;
    logic                   out_ready;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fifo_rr_controller #(
        .WIDTH(WIDTH),
        .N_REQ(N_REQ),
        .REQ_W(REQ_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .fifo_wr_en(fifo_wr_en),
        .fifo_din  (fifo_din),
        .fifo_full (fifo_full),
        .fifo_rd_en(fifo_rd_en),
        .fifo_dout (fifo_dout),
        .fifo_empty(fifo_empty),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  rv;
        logic [31:0] data;
        logic        full;
        logic        empty;
        logic        oready;
        logic [3:0]  e_ready;
        logic        e_wr;
        logic [9:0]  e_din;
        logic        e_rd;
        logic        e_ov;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic [3:0] rv, input logic [31:0] d,
                                input logic full, input logic empty, input logic [3:0] e_ready,
                                input logic e_wr, input logic [9:0] e_din, input logic e_rd);
        vec_t v;
        v.rst = r; v.rv = rv; v.data = d; v.full = full; v.empty = empty; v.oready = 1'b1;
        v.e_ready = e_ready; v.e_wr = e_wr; v.e_din = e_din; v.e_rd = e_rd; v.e_ov = 1'b0;
        return v;
    endfunction

    // Advance one clock: inputs change #1 after the rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_read(input string tag, input logic rd, input logic ov,
                            input logic [1:0] src, input logic [7:0] data, input logic chk_data);
        @(negedge clk);
        check({tag, "_rd_en"}, 32'(fifo_rd_en), 32'(rd));
        check({tag, "_out_valid"}, 32'(out_valid), 32'(ov));
        if (chk_data) begin
            check({tag, "_out_src"}, 32'(out_src), 32'(src));
            check({tag, "_out_data"}, 32'(out_data), 32'(data));
        end
    endtask

    initial begin
        logic [31:0] d0;
        logic [31:0] d2;
        d0 = 32'h44_33_22_11;
        d2 = 32'h44_A5_22_11;

        rst = 1'b1; req_valid = 4'hF; req_data = d0; fifo_full = 1'b0;
        fifo_empty = 1'b0; fifo_dout = '0; out_ready = 1'b1;
        next_cycle();

        // Reset held three cycles with requests and a non-empty FIFO.
        repeat (3) vq.push_back(mk(1'b1, 4'hF, d0, 1'b0, 1'b0, 4'h0, 1'b0, 10'h000, 1'b0));
        // Round robin with everyone requesting: 0,1,2,3,0.
        vq.push_back(mk(1'b0, 4'hF, d0, 1'b0, 1'b1, 4'b0001, 1'b1, 10'h011, 1'b0));
        vq.push_back(mk(1'b0, 4'hF, d0, 1'b0, 1'b1, 4'b0010, 1'b1, 10'h122, 1'b0));
        vq.push_back(mk(1'b0, 4'hF, d0, 1'b0, 1'b1, 4'b0100, 1'b1, 10'h233, 1'b0));
        vq.push_back(mk(1'b0, 4'hF, d0, 1'b0, 1'b1, 4'b1000, 1'b1, 10'h344, 1'b0));
        vq.push_back(mk(1'b0, 4'hF, d0, 1'b0, 1'b1, 4'b0001, 1'b1, 10'h011, 1'b0));
        // Sparse requests: ptr=1 skips to 2, ptr=3 wraps to 0, then 1.
        vq.push_back(mk(1'b0, 4'b0101, d0, 1'b0, 1'b1, 4'b0100, 1'b1, 10'h233, 1'b0));
        vq.push_back(mk(1'b0, 4'b0101, d0, 1'b0, 1'b1, 4'b0001, 1'b1, 10'h011, 1'b0));
        vq.push_back(mk(1'b0, 4'b0000, d0, 1'b0, 1'b1, 4'b0000, 1'b0, 10'h000, 1'b0));
        vq.push_back(mk(1'b0, 4'b0010, d0, 1'b0, 1'b1, 4'b0010, 1'b1, 10'h122, 1'b0));
        // Full stall with ptr=2: no grant, ptr held, producer 2 wins on release.
        vq.push_back(mk(1'b0, 4'b0110, d2, 1'b1, 1'b1, 4'b0000, 1'b0, 10'h000, 1'b0));
        vq.push_back(mk(1'b0, 4'b0110, d2, 1'b1, 1'b1, 4'b0000, 1'b0, 10'h000, 1'b0));
        vq.push_back(mk(1'b0, 4'b0110, d2, 1'b0, 1'b1, 4'b0100, 1'b1, 10'h2A5, 1'b0));
        vq.push_back(mk(1'b0, 4'b0110, d2, 1'b0, 1'b1, 4'b0010, 1'b1, 10'h122, 1'b0));

        foreach (vq[i]) begin
            rst = vq[i].rst; req_valid = vq[i].rv; req_data = vq[i].data;
            fifo_full = vq[i].full; fifo_empty = vq[i].empty; out_ready = vq[i].oready;
            @(negedge clk);
            check($sformatf("v%0d_req_ready", i), 32'(req_ready), 32'(vq[i].e_ready));
            check($sformatf("v%0d_wr_en", i), 32'(fifo_wr_en), 32'(vq[i].e_wr));
            if (vq[i].e_wr)
                check($sformatf("v%0d_din", i), 32'(fifo_din), 32'(vq[i].e_din));
            check($sformatf("v%0d_rd_en", i), 32'(fifo_rd_en), 32'(vq[i].e_rd));
            check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vq[i].e_ov));
            next_cycle();
        end

        // Read sequencing: two words {1,3C} then {3,7E}.
        req_valid = '0; fifo_full = 1'b0; out_ready = 1'b1;
        fifo_empty = 1'b0;
        chk_read("rd_a", 1'b1, 1'b0, 2'd0, 8'h00, 1'b0);
        next_cycle();
        fifo_dout = 10'h13C;
        chk_read("rd_pend1", 1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
        next_cycle();
        fifo_dout = 10'h3FF;
        chk_read("rd_w1", 1'b1, 1'b1, 2'd1, 8'h3C, 1'b1);
        next_cycle();
        fifo_dout = 10'h37E; fifo_empty = 1'b1;
        chk_read("rd_pend2", 1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
        next_cycle();
        fifo_dout = 10'h3FF; fifo_empty = 1'b0; out_ready = 1'b0;

        // Backpressure: word held stable, no read strobe for five cycles.
        for (int k = 0; k < 5; k++) begin
            chk_read($sformatf("bp%0d", k), 1'b0, 1'b1, 2'd3, 8'h7E, 1'b1);
            next_cycle();
        end
        out_ready = 1'b1;
        chk_read("bp_release", 1'b1, 1'b1, 2'd3, 8'h7E, 1'b1);
        next_cycle();
        fifo_dout = 10'h05A; fifo_empty = 1'b1;
        chk_read("bp_pend", 1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
        next_cycle();
        fifo_dout = 10'h3FF;
        chk_read("rd_w3", 1'b0, 1'b1, 2'd0, 8'h5A, 1'b1);
        next_cycle();
        chk_read("rd_idle", 1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
        next_cycle();

        // Reset while a read is pending: capture discarded, back to IDLE.
        fifo_empty = 1'b0;
        chk_read("rp_start", 1'b1, 1'b0, 2'd0, 8'h00, 1'b0);
        next_cycle();
        fifo_dout = 10'h2C3; rst = 1'b1;
        chk_read("rp_rst", 1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
        next_cycle();
        rst = 1'b0; fifo_empty = 1'b1; fifo_dout = 10'h3FF;
        chk_read("rp_after", 1'b0, 1'b0, 2'd0, 8'h00, 1'b1);
        next_cycle();
        out_ready = 1'b0; fifo_empty = 1'b0;
        chk_read("rp_idle", 1'b1, 1'b0, 2'd0, 8'h00, 1'b1);
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
